// File: rtl/uart_fifo_ptr_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_ptr_if
//   Bundles the data-path and status signals of the UART pointer FIFO.
//   Clock, reset and the clock request stay plain ports on the FIFO itself.
//
//   Handshake semantics (both sides are strict valid/ready):
//     write side: push is "valid", !full is "ready". An entry is taken in a
//                 cycle with push && (!full || pop) && !flush. A push against
//                 a full FIFO without a pop is dropped, not held.
//     read side : out_valid is "valid", pop is "ready". out_data is the
//                 entry consumed in a cycle with pop && out_valid && !flush.
//     flush wins over both sides in the cycle it is asserted.
//
//   Signals (direction seen from the FIFO, i.e. the slave modport):
//     flush      in   discard all contents
//     push       in   write in_data
//     in_data    in   write data, WIDTH bits
//     full       out  level == DEPTH
//     pop        in   consume out_data
//     out_valid  out  level != 0
//     out_data   out  entry at the read pointer
//     level      out  occupancy 0..DEPTH, CW bits
//     thresh     in   threshold value, CW bits
//     thresh_hit out  level >= thresh
//     overflow   out  sticky: push dropped
//     underflow  out  sticky: pop while empty
//     err_clear  in   clear sticky flags
//
//   master: the UART register side / serialiser that drives the FIFO.
//   slave : the FIFO.
// ---------------------------------------------------------------------------
interface uart_fifo_ptr_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             push;
  logic [WIDTH-1:0] in_data;
  logic             full;
  logic             pop;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    level;
  logic [CW-1:0]    thresh;
  logic             thresh_hit;
  logic             overflow;
  logic             underflow;
  logic             err_clear;

  modport master (
    output flush, push, in_data, pop, thresh, err_clear,
    input  full, out_valid, out_data, level, thresh_hit, overflow, underflow
  );

  modport slave (
    input  flush, push, in_data, pop, thresh, err_clear,
    output full, out_valid, out_data, level, thresh_hit, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_ptr.sv
// ---------------------------------------------------------------------------
// uart_fifo_ptr
//   Pointer-based circular-buffer FIFO for the UART TX and RX paths, with
//   first-word-fall-through output, occupancy count, programmable threshold
//   flag, synchronous flush and optional sticky error flags.
//
//   Parameters
//     DEPTH  entries, power of two, >= 2 (pointers wrap by natural overflow)
//     WIDTH  bits per entry
//     CW     derived count width, $clog2(DEPTH)+1
//
//   Ports
//     g_clk      in   clock
//     g_resetn   in   synchronous, active-low reset
//     g_clk_req  out  clock request: high whenever any input wants action
//     bus        slave modport of uart_fifo_ptr_if (data path + status)
//
//   Optional feature
//     UART_FIFO_ERR_FLAGS_EN  when defined, overflow/underflow are sticky
//                             flags cleared by err_clear; when undefined,
//                             both are tied 0 and dropped pushes / empty
//                             pops are discarded silently.
// ---------------------------------------------------------------------------
module uart_fifo_ptr #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  output logic              g_clk_req,
  uart_fifo_ptr_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Storage is deliberately not reset; out_data is only meaningful with
  // out_valid high.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] level_r;

  logic full_w;
  logic valid_w;
  logic push_ok;
  logic pop_ok;

  // Status is derived from the level register only, never from inputs.
  assign full_w  = (level_r == CW'(DEPTH));
  assign valid_w = (level_r != '0);

  // A pop on a full FIFO frees a slot in the same cycle, so a push is
  // accepted alongside it. Flush suppresses both sides.
  assign push_ok = bus.push && (!full_w || bus.pop) && !bus.flush;
  assign pop_ok  = bus.pop && valid_w && !bus.flush;

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_r <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous accept on both sides leaves level unchanged.
      case ({push_ok, pop_ok})
        2'b10:   level_r <= level_r + CW'(1);
        2'b01:   level_r <= level_r - CW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage write. push_ok already excludes flush; reset does not gate the
  // write because contents are discarded by the pointer reset anyway.
  // -------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic ovf_r;
  logic unf_r;
  logic ovf_set;
  logic unf_set;

  assign ovf_set = bus.push && full_w && !bus.pop && !bus.flush;
  assign unf_set = bus.pop && !valid_w && !bus.flush;

  // A new error in the clearing cycle must not be lost, so set wins.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_r <= 1'b1;
      end else if (bus.err_clear) begin
        ovf_r <= 1'b0;
      end
      if (unf_set) begin
        unf_r <= 1'b1;
      end else if (bus.err_clear) begin
        unf_r <= 1'b0;
      end
    end
  end

  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.full      = full_w;
  assign bus.out_valid = valid_w;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.level     = level_r;

  // Combinational on thresh. level never exceeds DEPTH, so any thresh above
  // DEPTH can never be reached; thresh == 0 is always hit, including reset.
  assign bus.thresh_hit = (level_r >= bus.thresh);

  // A FIFO holding only state needs no clock; any requested action does.
  assign g_clk_req = bus.push | bus.pop | bus.flush | bus.err_clear;

endmodule
